handle_mark: RTL and testbench
==============================

// Module: handle_mark
// PURPOSE
//  Reads the board produced by the selection stage: num_to_pos maps number -> board position.
//  For each called number it marks that position, rescans all 12 bingo lines (5 rows, 5 cols, 2 diagonals),
//  and publishes the completed-line count plus a bingo flag to the game controller and display.
//  One call is in flight at a time; a scan is sequential, one line per cycle.
// PARAMETERS
//  LINES_TO_WIN  5  completed lines required to assert bingo (legal range 1..12)
// PORTS
//  clk              in   1    system clock
//  rst_n            in   1    synchronous reset, active-low
//  interboard_rst   in   1    synchronous reset, active-high; same effect as rst_n=0
//  clear_mark       in   1    synchronous clear of marks and count (new game)
//  board_ready      in   1    board complete; calls are accepted only while 1
//  num_to_pos       in   125  slot for number n (1..25) = bits [n*5-1 -: 5], holds position 0..24
//  call_valid       in   1    a called number is presented this cycle
//  call_number_BCD  in   8    called number, BCD: [7:4] tens, [3:0] units
//  busy             out  1    1 from accept through DONE; calls are ignored while 1
//  call_reject      out  1    1-cycle pulse: call not accepted (bad number, bad pos, or already marked)
//  mark_done        out  1    1-cycle pulse: scan finished, line_count/bingo updated
//  marked           out  25   bit p = board position p (p = row*5+col) is marked
//  line_count       out  4    completed lines, 0..12
//  bingo            out  1    line_count >= LINES_TO_WIN (combinational from line_count)
// BEHAVIOUR
//  Reset (rst_n=0 or interboard_rst=1, sampled on clk): state=IDLE, marked=0, line_count=0,
//   busy=0, call_reject=0, mark_done=0, scan index=0, accumulator=0.
//  Priority: reset > clear_mark > everything else. clear_mark zeroes marked and line_count,
//   aborts any scan, returns to IDLE, and suppresses call_reject/mark_done that cycle.
//  n = 10*tens + units (7-bit); pos = num_to_pos[n*5-1 -: 5].
//  States: IDLE -> SCAN -> DONE -> IDLE.
//  IDLE, call_valid=1, board_ready=1:
//   - accept if 1<=n<=25, pos<=24, marked[pos]=0: marked[pos]<=1, idx<=0, acc<=0, go SCAN.
//   - otherwise: call_reject=1 next cycle, state and marks unchanged.
//  IDLE, call_valid=1, board_ready=0: call ignored, no reject.
//  SCAN (12 cycles, idx 0..11): line idx is full when all 5 of its marked bits are 1;
//   acc += full. Lines: idx 0-4 row idx (positions 5*idx..5*idx+4); idx 5-9 col idx-5
//   (positions c, c+5, ..., c+20); idx 10 = {0,6,12,18,24}; idx 11 = {4,8,12,16,20}.
//   Scan reads the already updated marked register. At idx=11: line_count <= acc + full, go DONE.
//  DONE (1 cycle): mark_done=1; go IDLE.
//  Latency: accept at cycle 0 -> SCAN cycles 1..12 -> mark_done=1 and new line_count in cycle 13;
//   next call can be accepted in cycle 14.
//  busy=1 in SCAN and DONE. call_valid while busy is dropped silently; it is not queued.
//  line_count is recomputed from scratch each scan, never incremented; it is non-decreasing
//   between clears because marks are never removed. bingo stays 1 until clear or reset.
//  Reset or clear mid-scan: scan abandoned, no mark_done, line_count=0.
//  Outputs call_reject, mark_done, busy are registered. bingo is combinational.
// TESTING
//  1. Identity board (num n at pos n-1), call BCD 01,02,03,04,05 -> after 5th call:
//     mark_done 13 cycles after accept, line_count=1, marked=25'h1F, bingo=0.
//  2. Call 01,07,13,19,25 on identity board -> line_count=1 (main diagonal);
//     then call 02..05 -> line_count=2.
//  3. Call BCD 00, BCD 26, then 03 twice -> call_reject pulses for 00, 26 and the 2nd 03;
//     marked changes only once.
//  4. call_valid during SCAN -> no accept, no reject, busy=1.
//     board_ready=0 -> call ignored, marked unchanged.
//  5. Mark rows 0-4 (25 calls) -> line_count=12, bingo=1 from the 5th-line scan onward
//     (LINES_TO_WIN=5).
//  6. clear_mark asserted mid-SCAN -> next cycle IDLE, marked=0, line_count=0, no mark_done;
//     same check with rst_n=0 and with interboard_rst=1.

Source files
------------

// File: rtl/handle_mark.sv
// ============================================================================
//  Module   : handle_mark
//  Purpose  : Marks called bingo numbers on the board, rescans all 12 lines
//             sequentially and publishes the completed-line count and bingo.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module handle_mark #(
    parameter int LINES_TO_WIN = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         interboard_rst,
    input  logic         clear_mark,
    input  logic         board_ready,
    input  logic [124:0] num_to_pos,
    input  logic         call_valid,
    input  logic [7:0]   call_number_BCD,
    output logic         busy,
    output logic         call_reject,
    output logic         mark_done,
    output logic [24:0]  marked,
    output logic [3:0]   line_count,
    output logic         bingo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_LINE = 4'd11;

    state_t      r_state, w_state_nxt;
    logic [24:0] r_marked, w_marked_nxt;
    logic [3:0]  r_line_count, w_count_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_acc, w_acc_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_reject, w_reject_nxt;
    logic        r_done, w_done_nxt;

    logic        w_rst;
    logic [6:0]  w_num;
    logic        w_num_ok;
    logic [4:0]  w_pos;
    logic        w_pos_marked;
    logic        w_accept;
    logic [24:0] w_line_mask;
    logic        w_line_full;
    logic [3:0]  w_acc_sum;

    assign w_rst    = ~rst_n | interboard_rst;
    assign w_num    = ({3'b000, call_number_BCD[7:4]} * 7'd10) + {3'b000, call_number_BCD[3:0]};
    assign w_num_ok = (w_num >= 7'd1) && (w_num <= 7'd25);

    // Board lookup only for legal numbers so the slice never leaves the vector.
    always_comb begin
        w_pos = 5'd0;
        for (int n = 1; n <= 25; n++) begin
            if (w_num == 7'(n)) begin
                w_pos = num_to_pos[n*5-1 -: 5];
            end
        end
    end

    always_comb begin
        w_pos_marked = 1'b0;
        for (int p = 0; p < 25; p++) begin
            if (w_pos == 5'(p)) begin
                w_pos_marked = r_marked[p];
            end
        end
    end

    assign w_accept = w_num_ok && (w_pos <= 5'd24) && !w_pos_marked;

    always_comb begin
        case (r_idx)
            4'd0:    w_line_mask = 25'h000001F;
            4'd1:    w_line_mask = 25'h00003E0;
            4'd2:    w_line_mask = 25'h0007C00;
            4'd3:    w_line_mask = 25'h00F8000;
            4'd4:    w_line_mask = 25'h1F00000;
            4'd5:    w_line_mask = 25'h0108421;
            4'd6:    w_line_mask = 25'h0210842;
            4'd7:    w_line_mask = 25'h0421084;
            4'd8:    w_line_mask = 25'h0842108;
            4'd9:    w_line_mask = 25'h1084210;
            4'd10:   w_line_mask = 25'h1041041;
            4'd11:   w_line_mask = 25'h0111110;
            default: w_line_mask = 25'h0000000;
        endcase
    end

    assign w_line_full = ((r_marked & w_line_mask) == w_line_mask) && (w_line_mask != 25'h0);
    assign w_acc_sum   = r_acc + {3'b000, w_line_full};

    always_comb begin
        w_state_nxt  = r_state;
        w_marked_nxt = r_marked;
        w_count_nxt  = r_line_count;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_acc;
        w_busy_nxt   = r_busy;
        w_reject_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        if (clear_mark) begin
            w_state_nxt  = S_IDLE;
            w_marked_nxt = 25'h0;
            w_count_nxt  = 4'd0;
            w_idx_nxt    = 4'd0;
            w_acc_nxt    = 4'd0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (call_valid && board_ready) begin
                        if (w_accept) begin
                            w_marked_nxt = r_marked | (25'd1 << w_pos);
                            w_idx_nxt    = 4'd0;
                            w_acc_nxt    = 4'd0;
                            w_busy_nxt   = 1'b1;
                            w_state_nxt  = S_SCAN;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    w_acc_nxt = w_acc_sum;
                    if (r_idx == c_LAST_LINE) begin
                        w_count_nxt = w_acc_sum;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_marked     <= 25'h0;
            r_line_count <= 4'd0;
            r_idx        <= 4'd0;
            r_acc        <= 4'd0;
            r_busy       <= 1'b0;
            r_reject     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_marked     <= w_marked_nxt;
            r_line_count <= w_count_nxt;
            r_idx        <= w_idx_nxt;
            r_acc        <= w_acc_nxt;
            r_busy       <= w_busy_nxt;
            r_reject     <= w_reject_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign busy        = r_busy;
    assign call_reject = r_reject;
    assign mark_done   = r_done;
    assign marked      = r_marked;
    assign line_count  = r_line_count;
    assign bingo       = (r_line_count >= 4'(LINES_TO_WIN));

endmodule

`default_nettype wire

// File: tb/tb_handle_mark.sv
// ============================================================================
//  Module   : tb_handle_mark
//  Purpose  : Scoreboard bench for handle_mark with directed call sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_handle_mark;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         interboard_rst = 1'b0;
    logic         clear_mark = 1'b0;
    logic         board_ready = 1'b1;
    logic [124:0] num_to_pos = '0;
    logic         call_valid = 1'b0;
    logic [7:0]   call_number_BCD = 8'h00;
    logic         busy, call_reject, mark_done, bingo;
    logic [24:0]  marked;
    logic [3:0]   line_count;

    handle_mark #(.LINES_TO_WIN(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .interboard_rst  (interboard_rst),
        .clear_mark      (clear_mark),
        .board_ready     (board_ready),
        .num_to_pos      (num_to_pos),
        .call_valid      (call_valid),
        .call_number_BCD (call_number_BCD),
        .busy            (busy),
        .call_reject     (call_reject),
        .mark_done       (mark_done),
        .marked          (marked),
        .line_count      (line_count),
        .bingo           (bingo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        int          due;
        logic [3:0]  lc;
        logic [24:0] mk;
        logic        bng;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [24:0] exp_mk = '0;
    logic [3:0]  exp_lc = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every reject/done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (mark_done || call_reject) begin
            if (q.size() == 0) begin
                check("unexpected_event", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("event_kind", {31'd0, mark_done}, {31'd0, mon_e.is_done});
                check("event_cycle", cyc, mon_e.due);
                check("line_count", {28'd0, line_count}, {28'd0, mon_e.lc});
                check("marked", {7'd0, marked}, {7'd0, mon_e.mk});
                check("bingo", {31'd0, bingo}, {31'd0, mon_e.bng});
            end
        end
    end

    // Drives one call for one cycle; returns at the negedge of the cycle after it.
    task automatic issue(input logic [7:0] bcd, input bit acc, input int pos,
                         input logic [3:0] lc, input bit track);
        exp_t e;
        @(negedge clk);
        call_valid      = 1'b1;
        call_number_BCD = bcd;
        if (acc) begin
            exp_mk    = exp_mk | (25'd1 << pos);
            exp_lc    = lc;
            e.is_done = 1'b1;
            e.due     = cyc + 13;
        end else begin
            e.is_done = 1'b0;
            e.due     = cyc + 1;
        end
        e.lc  = exp_lc;
        e.mk  = exp_mk;
        e.bng = (exp_lc >= 4'd5);
        if (track) q.push_back(e);
        @(negedge clk);
        call_valid = 1'b0;
    endtask

    task automatic do_call(input logic [7:0] bcd, input bit acc, input int pos, input logic [3:0] lc);
        issue(bcd, acc, pos, lc, 1'b1);
        if (acc) repeat (12) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_mark = 1'b1;
        @(negedge clk);
        clear_mark = 1'b0;
        exp_mk = '0;
        exp_lc = '0;
        check("clear_marked", {7'd0, marked}, 32'd0);
        check("clear_count", {28'd0, line_count}, 32'd0);
    endtask

    // kind 0: clear_mark, 1: rst_n low, 2: interboard_rst high
    task automatic abort_scan(input int kind);
        do_clear();
        for (int n = 1; n <= 5; n++) do_call(8'(n), 1'b1, n - 1, (n == 5) ? 4'd1 : 4'd0);
        issue(8'h06, 1'b1, 5, 4'd1, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        case (kind)
            0: clear_mark = 1'b1;
            1: rst_n = 1'b0;
            default: interboard_rst = 1'b1;
        endcase
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_marked", {7'd0, marked}, 32'd0);
        check("abort_count", {28'd0, line_count}, 32'd0);
        check("abort_done", {31'd0, mark_done}, 32'd0);
        @(negedge clk);
        clear_mark     = 1'b0;
        rst_n          = 1'b1;
        interboard_rst = 1'b0;
        exp_mk = '0;
        exp_lc = '0;
        repeat (16) @(negedge clk);
    endtask

    function automatic logic [3:0] rows_lc(input int n);
        if (n < 5)       return 4'd0;
        else if (n < 10) return 4'd1;
        else if (n < 15) return 4'd2;
        else if (n < 20) return 4'd3;
        else if (n == 20) return 4'd4;
        else if (n == 25) return 4'd12;
        else             return 4'(n - 15);
    endfunction

    initial begin
        for (int n = 1; n <= 25; n++) num_to_pos[n*5-1 -: 5] = 5'(n - 1);

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_reject", {31'd0, call_reject}, 32'd0);
        check("rst_done", {31'd0, mark_done}, 32'd0);
        check("rst_marked", {7'd0, marked}, 32'd0);
        check("rst_count", {28'd0, line_count}, 32'd0);
        check("rst_bingo", {31'd0, bingo}, 32'd0);
        rst_n = 1'b1;

        // Row 0, with back-to-back acceptance at cycle 14
        for (int n = 1; n <= 5; n++) do_call(8'(n), 1'b1, n - 1, (n == 5) ? 4'd1 : 4'd0);
        check("row0_marked", {7'd0, marked}, 32'h1F);

        // Main diagonal then the rest of row 0
        do_clear();
        do_call(8'h01, 1'b1, 0, 4'd0);
        do_call(8'h07, 1'b1, 6, 4'd0);
        do_call(8'h13, 1'b1, 12, 4'd0);
        do_call(8'h19, 1'b1, 18, 4'd0);
        do_call(8'h25, 1'b1, 24, 4'd1);
        do_call(8'h02, 1'b1, 1, 4'd1);
        do_call(8'h03, 1'b1, 2, 4'd1);
        do_call(8'h04, 1'b1, 3, 4'd1);
        do_call(8'h05, 1'b1, 4, 4'd2);

        // Rejects: out of range numbers and a repeat call
        do_clear();
        do_call(8'h00, 1'b0, 0, 4'd0);
        do_call(8'h26, 1'b0, 0, 4'd0);
        do_call(8'h03, 1'b1, 2, 4'd0);
        do_call(8'h03, 1'b0, 0, 4'd0);
        check("repeat_marked", {7'd0, marked}, 32'h4);

        // Call while scanning is dropped; call without board_ready is ignored
        issue(8'h04, 1'b1, 3, 4'd0, 1'b1);
        repeat (2) @(negedge clk);
        call_valid      = 1'b1;
        call_number_BCD = 8'h05;
        check("busy_in_scan", {31'd0, busy}, 32'd1);
        @(negedge clk);
        call_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("dropped_marked", {7'd0, marked}, 32'hC);
        board_ready     = 1'b0;
        call_valid      = 1'b1;
        call_number_BCD = 8'h06;
        @(negedge clk);
        call_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("not_ready_marked", {7'd0, marked}, 32'hC);
        check("not_ready_busy", {31'd0, busy}, 32'd0);
        board_ready = 1'b1;

        // Board slot holding an illegal position
        num_to_pos[9*5-1 -: 5] = 5'd31;
        do_call(8'h09, 1'b0, 0, 4'd0);
        num_to_pos[9*5-1 -: 5] = 5'd8;

        // Full board: 12 lines, bingo from the 21st call onward
        do_clear();
        for (int n = 1; n <= 25; n++)
            do_call({4'(n / 10), 4'(n % 10)}, 1'b1, n - 1, rows_lc(n));
        check("full_bingo", {31'd0, bingo}, 32'd1);

        abort_scan(0);
        abort_scan(1);
        abort_scan(2);

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
